// File: rtl/lut_fetch_scheduler.sv
// Sequencing controller for the tetrahedral 3D-LUT path: serialises four vertex reads onto one
// single-port SRAM, feeds the calculator, registers its results and arbitrates host LUT loads.
module lut_fetch_scheduler #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LUT_DEPTH = 3392
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [7:0]        i_in_center,
    input  logic [7:0]        i_in_data1,
    input  logic [7:0]        i_in_data2,
    output logic [7:0]        o_calc_center,
    output logic [7:0]        o_calc_data1,
    output logic [7:0]        o_calc_data2,
    input  logic [ADDR_W-1:0] i_calc_addr0,
    input  logic [ADDR_W-1:0] i_calc_addr1,
    input  logic [ADDR_W-1:0] i_calc_addr2,
    input  logic [ADDR_W-1:0] i_calc_addr3,
    output logic [DATA_W-1:0] o_calc_o0,
    output logic [DATA_W-1:0] o_calc_o1,
    output logic [DATA_W-1:0] o_calc_o2,
    output logic [DATA_W-1:0] o_calc_o3,
    input  logic [10:0]       i_calc_out1,
    input  logic [10:0]       i_calc_out2,
    input  logic [10:0]       i_calc_out3,
    input  logic [10:0]       i_calc_out4,
    output logic              o_sram_cs,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata,
    input  logic              i_host_wr_req,
    input  logic [ADDR_W-1:0] i_host_wr_addr,
    input  logic [DATA_W-1:0] i_host_wr_data,
    output logic              o_host_wr_ack,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [43:0]       o_out_res,
    output logic              o_addr_err
);

    localparam logic [ADDR_W:0] LutDepth = (ADDR_W + 1)'(LUT_DEPTH);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StDrive, StCapt, StOut} state_e;

    state_e                     r_state;
    state_e                     w_state_nxt;
    logic [1:0]                 r_k;
    logic [7:0]                 r_center;
    logic [7:0]                 r_data1;
    logic [7:0]                 r_data2;
    logic [3:0][DATA_W-1:0]     r_o;
    logic                       r_cap_pend;
    logic                       r_cap_zero;
    logic [1:0]                 r_cap_idx;
    logic [43:0]                r_res;
    logic                       r_addr_err;
    logic [ADDR_W-1:0]          w_fetch_addr;
    logic                       w_fetch_oor;
    logic                       w_host_ok;
    logic                       w_accept;

    always_comb begin
        unique case (r_k)
            2'd0: w_fetch_addr = i_calc_addr0;
            2'd1: w_fetch_addr = i_calc_addr1;
            2'd2: w_fetch_addr = i_calc_addr2;
            2'd3: w_fetch_addr = i_calc_addr3;
        endcase
    end

    assign w_fetch_oor = ({1'b0, w_fetch_addr} >= LutDepth);
    assign w_host_ok   = ({1'b0, i_host_wr_addr} < LutDepth);

    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        o_in_ready    = 1'b0;
        o_host_wr_ack = 1'b0;
        o_sram_cs     = 1'b0;
        o_sram_we     = 1'b0;
        o_sram_addr   = '0;
        o_sram_wdata  = '0;
        case (r_state)
            StIdle: begin
                // Host has strict priority; out-of-range writes are acked and dropped.
                if (i_host_wr_req) begin
                    o_host_wr_ack = 1'b1;
                    if (w_host_ok) begin
                        o_sram_cs    = 1'b1;
                        o_sram_we    = 1'b1;
                        o_sram_addr  = i_host_wr_addr;
                        o_sram_wdata = i_host_wr_data;
                    end
                end else begin
                    o_in_ready = 1'b1;
                    if (i_in_valid) begin
                        w_accept    = 1'b1;
                        w_state_nxt = StFetch;
                    end
                end
            end
            StFetch: begin
                if (!w_fetch_oor) begin
                    o_sram_cs   = 1'b1;
                    o_sram_addr = w_fetch_addr;
                end
                if (r_k == 2'd3) w_state_nxt = StWait;
            end
            StWait:  w_state_nxt = StDrive;
            StDrive: w_state_nxt = StCapt;
            StCapt:  w_state_nxt = StOut;
            StOut:   if (i_out_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        // Combinational outputs read as zero while reset is held.
        if (!i_rst_n) begin
            w_accept      = 1'b0;
            o_in_ready    = 1'b0;
            o_host_wr_ack = 1'b0;
            o_sram_cs     = 1'b0;
            o_sram_we     = 1'b0;
            o_sram_addr   = '0;
            o_sram_wdata  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_k        <= 2'd0;
            r_center   <= '0;
            r_data1    <= '0;
            r_data2    <= '0;
            r_o        <= '0;
            r_cap_pend <= 1'b0;
            r_cap_zero <= 1'b0;
            r_cap_idx  <= 2'd0;
            r_res      <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_center <= i_in_center;
                r_data1  <= i_in_data1;
                r_data2  <= i_in_data2;
                r_k      <= 2'd0;
            end else if (r_state == StFetch) begin
                r_k <= r_k + 2'd1;
            end
            // Read data returns one cycle after issue; skipped reads land as zero.
            r_cap_pend <= (r_state == StFetch);
            r_cap_idx  <= r_k;
            r_cap_zero <= w_fetch_oor;
            if (r_cap_pend) r_o[r_cap_idx] <= r_cap_zero ? '0 : i_sram_rdata;
            if ((r_state == StFetch) && w_fetch_oor) r_addr_err <= 1'b1;
            if (r_state == StCapt) r_res <= {i_calc_out1, i_calc_out2, i_calc_out3, i_calc_out4};
        end
    end

    assign o_calc_center = r_center;
    assign o_calc_data1  = r_data1;
    assign o_calc_data2  = r_data2;
    assign o_calc_o0     = r_o[0];
    assign o_calc_o1     = r_o[1];
    assign o_calc_o2     = r_o[2];
    assign o_calc_o3     = r_o[3];
    assign o_out_valid   = (r_state == StOut);
    assign o_out_res     = r_res;
    assign o_addr_err    = r_addr_err;

endmodule

// File: tb/tb_lut_fetch_scheduler.sv
// Bench for lut_fetch_scheduler: behavioural SRAM and calculator around the DUT, with a
// reference that derives each result directly from a shadow copy of the LUT contents.
module tb_lut_fetch_scheduler;

    localparam int Depth = 3392;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready;
    logic [7:0]  in_c, in_d1, in_d2;
    logic [7:0]  calc_c, calc_d1, calc_d2;
    logic [11:0] calc_a0, calc_a1, calc_a2, calc_a3;
    logic [31:0] calc_o0, calc_o1, calc_o2, calc_o3;
    logic [10:0] calc_out1 = '0, calc_out2 = '0, calc_out3 = '0, calc_out4 = '0;
    logic        sram_cs, sram_we;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;
    logic        host_req, host_ack;
    logic [11:0] host_addr;
    logic [31:0] host_data;
    logic        out_valid, out_ready;
    logic [43:0] out_res;
    logic        addr_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int sram_oob = 0;
    logic tb_oor = 1'b0;

    logic [31:0] sram_mem [0:Depth-1];
    logic [31:0] shadow   [0:Depth-1];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lut_fetch_scheduler dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_center(in_c), .i_in_data1(in_d1), .i_in_data2(in_d2),
        .o_calc_center(calc_c), .o_calc_data1(calc_d1), .o_calc_data2(calc_d2),
        .i_calc_addr0(calc_a0), .i_calc_addr1(calc_a1),
        .i_calc_addr2(calc_a2), .i_calc_addr3(calc_a3),
        .o_calc_o0(calc_o0), .o_calc_o1(calc_o1), .o_calc_o2(calc_o2), .o_calc_o3(calc_o3),
        .i_calc_out1(calc_out1), .i_calc_out2(calc_out2),
        .i_calc_out3(calc_out3), .i_calc_out4(calc_out4),
        .o_sram_cs(sram_cs), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
        .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata),
        .i_host_wr_req(host_req), .i_host_wr_addr(host_addr), .i_host_wr_data(host_data),
        .o_host_wr_ack(host_ack),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_res(out_res),
        .o_addr_err(addr_err)
    );

    // Vertex address rule of the calculator model.
    function automatic logic [11:0] vaddr(input logic [7:0] c, d1, d2, input int k);
        return 12'((int'(c) * 13 + int'(d1) * 7 + int'(d2) * 3 + k * 97) % Depth);
    endfunction

    function automatic logic [10:0] lane_sum(input logic [31:0] w0, w1, w2, w3, input int j);
        int s;
        s = int'($signed(w0[8*j +: 8])) + int'($signed(w1[8*j +: 8]))
          + int'($signed(w2[8*j +: 8])) + int'($signed(w3[8*j +: 8]));
        return 11'(s);
    endfunction

    function automatic logic [43:0] ref_res(input logic [7:0] c, d1, d2, input bit oor);
        logic [31:0] w [4];
        logic [11:0] a;
        for (int k = 0; k < 4; k++) begin
            a = (oor && k == 2) ? 12'd3856 : vaddr(c, d1, d2, k);
            w[k] = (int'(a) < Depth) ? shadow[a] : 32'h0;
        end
        return {lane_sum(w[0], w[1], w[2], w[3], 0) + 11'(c[3:0]),
                lane_sum(w[0], w[1], w[2], w[3], 1) + 11'(d1[3:0]),
                lane_sum(w[0], w[1], w[2], w[3], 2) + 11'(d2[3:0]),
                lane_sum(w[0], w[1], w[2], w[3], 3)};
    endfunction

    always @(posedge clk) begin
        if (sram_cs) begin
            if (int'(sram_addr) >= Depth) sram_oob <= sram_oob + 1;
            else if (sram_we) sram_mem[sram_addr] <= sram_wdata;
            else sram_rdata <= sram_mem[sram_addr];
        end
    end

    always_comb begin
        calc_a0 = vaddr(calc_c, calc_d1, calc_d2, 0);
        calc_a1 = vaddr(calc_c, calc_d1, calc_d2, 1);
        calc_a2 = tb_oor ? 12'd3856 : vaddr(calc_c, calc_d1, calc_d2, 2);
        calc_a3 = vaddr(calc_c, calc_d1, calc_d2, 3);
    end

    always @(posedge clk) begin
        calc_out1 <= lane_sum(calc_o0, calc_o1, calc_o2, calc_o3, 0) + 11'(calc_c[3:0]);
        calc_out2 <= lane_sum(calc_o0, calc_o1, calc_o2, calc_o3, 1) + 11'(calc_d1[3:0]);
        calc_out3 <= lane_sum(calc_o0, calc_o1, calc_o2, calc_o3, 2) + 11'(calc_d2[3:0]);
        calc_out4 <= lane_sum(calc_o0, calc_o1, calc_o2, calc_o3, 3);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a pixel until it is accepted; returns the cycle count just after the accept edge.
    task automatic send(input logic [7:0] c, d1, d2, output int acc, output bit ok);
        in_c = c; in_d1 = d1; in_d2 = d2; in_valid = 1'b1; ok = 1'b0; acc = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            #2;
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) acc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int acc, output logic [43:0] res, output int lat, output bit ok);
        ok = 1'b0; res = '0; lat = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (out_valid) begin res = out_res; lat = cyc - acc; ok = 1'b1; end
            step();
        end
    endtask

    task automatic test_reset();
        host_req = 1'b1; host_addr = 12'd5; host_data = 32'h1234_5678; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_vec++; if (host_ack !== 1'b0) begin n_err++; $display("FAIL reset_host_ack: got %b want 0", host_ack); end
        n_vec++; if ({sram_cs, sram_we, sram_addr, sram_wdata} !== '0) begin n_err++;
            $display("FAIL reset_sram: got cs=%b we=%b a=%h d=%h want all 0", sram_cs, sram_we, sram_addr, sram_wdata); end
        n_vec++; if ({out_valid, out_res, addr_err} !== '0) begin n_err++;
            $display("FAIL reset_out: got v=%b res=%h err=%b want all 0", out_valid, out_res, addr_err); end
        n_vec++; if ({calc_c, calc_d1, calc_d2, calc_o0, calc_o1, calc_o2, calc_o3} !== '0) begin n_err++;
            $display("FAIL reset_calc: got %h %h %h %h want 0", calc_c, calc_o0, calc_o2, calc_o3); end
        host_req = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        #2;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
        step();
    endtask

    task automatic test_host_load();
        int acks = 0, writes = 0, rdy = 0, acc, lat;
        bit last_cs = 1'b1, ok;
        logic [43:0] res, exp;
        logic [7:0] c, d1, d2;
        for (int a = 0; a <= Depth; a++) begin
            host_req = 1'b1; host_addr = 12'(a); host_data = 32'(a) ^ 32'hA5A5_A5A5;
            #2;
            if (host_ack) acks++;
            if (host_ack && sram_cs && sram_we && sram_addr == 12'(a) && sram_wdata == host_data) writes++;
            if (in_ready) rdy++;
            if (a == Depth) last_cs = sram_cs;
            if (a < Depth) shadow[a] = host_data;
            @(posedge clk);
            #1;
        end
        host_req = 1'b0;
        n_vec++; if (acks != Depth + 1) begin n_err++; $display("FAIL load_acks: got %0d want %0d", acks, Depth + 1); end
        n_vec++; if (writes != Depth) begin n_err++; $display("FAIL load_writes: got %0d want %0d", writes, Depth); end
        n_vec++; if (last_cs !== 1'b0) begin n_err++; $display("FAIL load_oor_cs: got %b want 0", last_cs); end
        n_vec++; if (rdy != 0) begin n_err++; $display("FAIL load_in_ready: got %0d cycles want 0", rdy); end
        for (int p = 0; p < 4; p++) begin
            c = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
            exp = ref_res(c, d1, d2, 1'b0);
            send(c, d1, d2, acc, ok);
            collect(acc, res, lat, ok);
            n_vec++; if (!ok || res !== exp) begin n_err++; $display("FAIL load_readback: got %h want %h", res, exp); end
        end
    endtask

    task automatic test_single_pixel();
        int acc, early = 0;
        bit ok;
        logic [43:0] exp;
        exp = ref_res(8'h50, 8'h30, 8'h90, 1'b0);
        send(8'h50, 8'h30, 8'h90, acc, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_accept: got timeout want accept"); end
        for (int i = 1; i <= 8; i++) begin
            if (i <= 4) begin
                n_vec++;
                if ({sram_cs, sram_we, sram_addr} !== {2'b10, vaddr(8'h50, 8'h30, 8'h90, i - 1)}) begin
                    n_err++;
                    $display("FAIL single_read%0d: got cs=%b we=%b a=%0d want cs=1 we=0 a=%0d", i - 1,
                             sram_cs, sram_we, sram_addr, vaddr(8'h50, 8'h30, 8'h90, i - 1));
                end
            end
            if (i == 6) begin
                n_vec++;
                if ({calc_o0, calc_o1, calc_o2, calc_o3} !== {shadow[vaddr(8'h50, 8'h30, 8'h90, 0)],
                    shadow[vaddr(8'h50, 8'h30, 8'h90, 1)], shadow[vaddr(8'h50, 8'h30, 8'h90, 2)],
                    shadow[vaddr(8'h50, 8'h30, 8'h90, 3)]}) begin
                    n_err++; $display("FAIL single_calc_o: got %h %h %h %h", calc_o0, calc_o1, calc_o2, calc_o3);
                end
                n_vec++; if ({calc_c, calc_d1, calc_d2} !== 24'h503090) begin n_err++;
                    $display("FAIL single_calc_px: got %h%h%h want 503090", calc_c, calc_d1, calc_d2); end
            end
            if (i < 8 && out_valid) early++;
            if (i == 8) begin
                n_vec++; if (out_valid !== 1'b1 || cyc - acc != 7) begin n_err++;
                    $display("FAIL single_latency: got v=%b at %0d want v=1 at 7", out_valid, cyc - acc); end
                n_vec++; if (out_res !== exp) begin n_err++; $display("FAIL single_res: got %h want %h", out_res, exp); end
            end
            step();
        end
        n_vec++; if (early != 0) begin n_err++; $display("FAIL single_early_valid: got %0d want 0", early); end
        #2;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_idle_ready: got %b want 1", in_ready); end
        step();
    endtask

    task automatic test_contention();
        int acc, lat, busy_acks = 0;
        bit ok;
        logic [7:0] c, d1, d2, qc, qd1, qd2;
        logic [43:0] res, exp, expq;
        logic [31:0] wd;
        c = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        qc = 8'($urandom); qd1 = 8'($urandom); qd2 = 8'($urandom);
        wd = $urandom;
        host_req = 1'b1; host_addr = vaddr(c, d1, d2, 1); host_data = wd;
        in_c = c; in_d1 = d1; in_d2 = d2; in_valid = 1'b1;
        #2;
        n_vec++; if ({host_ack, in_ready, sram_cs, sram_we} !== 4'b1011) begin n_err++;
            $display("FAIL cont_host_first: got ack=%b rdy=%b cs=%b we=%b want 1 0 1 1", host_ack, in_ready, sram_cs, sram_we); end
        shadow[vaddr(c, d1, d2, 1)] = wd;
        @(posedge clk);
        #1;
        host_req = 1'b0;
        send(c, d1, d2, acc, ok);
        n_vec++; if (cyc - acc != 0 || !ok) begin n_err++; $display("FAIL cont_accept: got ok=%b want accepted", ok); end
        exp = ref_res(c, d1, d2, 1'b0);
        wd = $urandom;
        host_req = 1'b1; host_addr = vaddr(qc, qd1, qd2, 0); host_data = wd;
        res = '0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            if (host_ack) busy_acks++;
            if (i == 8) res = out_res;
            @(posedge clk);
            #1;
        end
        n_vec++; if (busy_acks != 0) begin n_err++; $display("FAIL cont_busy_ack: got %0d acks want 0", busy_acks); end
        #2;
        n_vec++; if ({host_ack, sram_cs, sram_we} !== 3'b111) begin n_err++;
            $display("FAIL cont_idle_ack: got ack=%b cs=%b we=%b want 1 1 1", host_ack, sram_cs, sram_we); end
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL cont_res: got %h want %h", res, exp); end
        shadow[vaddr(qc, qd1, qd2, 0)] = wd;
        @(posedge clk);
        #1;
        host_req = 1'b0;
        expq = ref_res(qc, qd1, qd2, 1'b0);
        send(qc, qd1, qd2, acc, ok);
        collect(acc, res, lat, ok);
        n_vec++; if (!ok || res !== expq) begin n_err++; $display("FAIL cont_readback: got %h want %h", res, expq); end
    endtask

    task automatic test_backpressure();
        int acc, lat, w = 0, bad_v = 0, bad_r = 0, bad_rdy = 0;
        bit ok;
        logic [43:0] res0, res, exp;
        logic [7:0] c, d1, d2;
        out_ready = 1'b0;
        c = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        exp = ref_res(c, d1, d2, 1'b0);
        send(c, d1, d2, acc, ok);
        while (!out_valid && w < 40) begin step(); w++; end
        n_vec++; if (out_valid !== 1'b1 || cyc - acc != 7) begin n_err++;
            $display("FAIL bp_latency: got v=%b at %0d want v=1 at 7", out_valid, cyc - acc); end
        res0 = out_res;
        n_vec++; if (res0 !== exp) begin n_err++; $display("FAIL bp_res: got %h want %h", res0, exp); end
        c = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        exp = ref_res(c, d1, d2, 1'b0);
        in_c = c; in_d1 = d1; in_d2 = d2; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (out_valid !== 1'b1) bad_v++;
            if (out_res !== res0) bad_r++;
            if (in_ready !== 1'b0) bad_rdy++;
            step();
        end
        n_vec++; if (bad_v != 0) begin n_err++; $display("FAIL bp_valid_stable: got %0d drops want 0", bad_v); end
        n_vec++; if (bad_r != 0) begin n_err++; $display("FAIL bp_res_stable: got %0d changes want 0", bad_r); end
        n_vec++; if (bad_rdy != 0) begin n_err++; $display("FAIL bp_in_ready: got %0d ready cycles want 0", bad_rdy); end
        out_ready = 1'b1;
        #2;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_xfer_ready: got %b want 0", in_ready); end
        step();
        #2;
        n_vec++; if ({in_ready, out_valid} !== 2'b10) begin n_err++;
            $display("FAIL bp_idle: got rdy=%b v=%b want 1 0", in_ready, out_valid); end
        step();
        acc = cyc;
        in_valid = 1'b0;
        collect(acc, res, lat, ok);
        n_vec++; if (!ok || lat != 7 || res !== exp) begin n_err++;
            $display("FAIL bp_next: got lat=%0d res=%h want lat=7 res=%h", lat, res, exp); end
    endtask

    task automatic test_out_of_range();
        int acc, lat;
        bit ok;
        logic [43:0] res, exp;
        logic [7:0] c, d1, d2;
        c = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        tb_oor = 1'b1;
        exp = ref_res(c, d1, d2, 1'b1);
        send(c, d1, d2, acc, ok);
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) begin
                n_vec++; if (sram_cs !== (i != 3)) begin n_err++;
                    $display("FAIL oor_cs%0d: got %b want %b", i - 1, sram_cs, i != 3); end
            end
            if (i == 6) begin
                n_vec++; if (calc_o2 !== 32'h0) begin n_err++; $display("FAIL oor_calc_o2: got %h want 0", calc_o2); end
            end
            step();
        end
        collect(acc, res, lat, ok);
        n_vec++; if (!ok || res !== exp) begin n_err++; $display("FAIL oor_res: got %h want %h", res, exp); end
        n_vec++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_err_set: got %b want 1", addr_err); end
        tb_oor = 1'b0;
        c = 8'($urandom);
        exp = ref_res(c, d1, d2, 1'b0);
        send(c, d1, d2, acc, ok);
        collect(acc, res, lat, ok);
        n_vec++; if (!ok || res !== exp) begin n_err++; $display("FAIL oor_after_res: got %h want %h", res, exp); end
        n_vec++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL oor_err_sticky: got %b want 1", addr_err); end
        n_vec++; if (sram_oob != 0) begin n_err++; $display("FAIL oor_sram_touch: got %0d want 0", sram_oob); end
    endtask

    task automatic test_reset_in_wait();
        int acc, lat, bad = 0;
        bit ok;
        logic [43:0] res, exp;
        logic [7:0] c, d1, d2;
        c = 8'($urandom) | 8'h01; d1 = 8'($urandom); d2 = 8'($urandom);
        send(c, d1, d2, acc, ok);
        repeat (4) step();
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++; if ({calc_c, calc_o0, calc_o1, out_res, out_valid, addr_err, sram_cs, in_ready, host_ack} !== '0) begin
            n_err++;
            $display("FAIL rst_wait_zero: got c=%h o0=%h res=%h v=%b err=%b cs=%b want all 0",
                     calc_c, calc_o0, out_res, out_valid, addr_err, sram_cs);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) bad++;
            step();
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL rst_wait_no_valid: got %0d want 0", bad); end
        exp = ref_res(d1, d2, c, 1'b0);
        send(d1, d2, c, acc, ok);
        collect(acc, res, lat, ok);
        n_vec++; if (!ok || lat != 7 || res !== exp) begin n_err++;
            $display("FAIL rst_wait_next: got lat=%0d res=%h want lat=7 res=%h", lat, res, exp); end
    endtask

    task automatic test_random_pixels();
        int acc, lat, unstable = 0, miss_ack = 0;
        bit ok, done;
        logic [43:0] res, exp;
        logic [7:0] c, d1, d2;
        logic [11:0] ha;
        for (int p = 0; p < 20; p++) begin
            if ($urandom_range(0, 2) == 0) begin
                ha = 12'($urandom_range(0, Depth - 1));
                host_req = 1'b1; host_addr = ha; host_data = $urandom;
                #2;
                if (!host_ack || !sram_we) miss_ack++;
                shadow[ha] = host_data;
                step();
                host_req = 1'b0;
            end
            c = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
            exp = ref_res(c, d1, d2, 1'b0);
            send(c, d1, d2, acc, ok);
            lat = -1; done = 1'b0; res = '0;
            for (int i = 0; i < 60 && !done; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid) begin
                    if (lat < 0) begin lat = cyc - acc; res = out_res; end
                    else if (out_res !== res) unstable++;
                    if (out_ready) done = 1'b1;
                end
                step();
            end
            out_ready = 1'b1;
            n_vec++; if (!ok || !done || lat != 7 || res !== exp) begin n_err++;
                $display("FAIL rand_px%0d: got ok=%b done=%b lat=%0d res=%h want lat=7 res=%h",
                         p, ok, done, lat, res, exp); end
        end
        n_vec++; if (unstable != 0) begin n_err++; $display("FAIL rand_stable: got %0d changes want 0", unstable); end
        n_vec++; if (miss_ack != 0) begin n_err++; $display("FAIL rand_host_ack: got %0d missed want 0", miss_ack); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; in_c = '0; in_d1 = '0; in_d2 = '0;
        host_req = 1'b0; host_addr = '0; host_data = '0; out_ready = 1'b1;
        #1;
        test_reset();
        test_host_load();
        test_single_pixel();
        test_contention();
        test_backpressure();
        test_out_of_range();
        test_reset_in_wait();
        test_random_pixels();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lut_fetch_scheduler.md
# lut_fetch_scheduler

Sequencing controller for the tetrahedral 3D-LUT interpolation path. It accepts one 8-bit triplet (center, data1, data2) per handshake and holds it on the direction calculator's pixel inputs. It serialises the calculator's four vertex addresses onto one single-port 3392×32 SRAM, then presents the four collected words back to the calculator. Finally it captures the four interpolated results into a valid/ready output register. It also arbitrates a host LUT-load write port onto the same SRAM.

## Interface
- ADDR_W, 12, SRAM/vertex address width
- DATA_W, 32, LUT word width (4 × signed 8-bit)
- LUT_DEPTH, 3392, valid SRAM words; addresses ≥ LUT_DEPTH are out of range
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid / in_ready  in / out  1  pixel handshake
- in_center, in_data1, in_data2  in  8 each  pixel triplet
- calc_center, calc_data1, calc_data2  out  8 each  held triplet to calculator
- calc_addr0..calc_addr3  in  ADDR_W each  vertex addresses from calculator (combinational from calc_*)
- calc_O0..calc_O3  out  DATA_W each  fetched words to calculator
- calc_out1..calc_out4  in  11 each  signed calculator results
- sram_cs, sram_we  out  1  SRAM select / write enable
- sram_addr  out  ADDR_W; sram_wdata  out  DATA_W; sram_rdata  in  DATA_W (1-cycle read latency)
- host_wr_req  in  1; host_wr_addr  in  ADDR_W; host_wr_data  in  DATA_W; host_wr_ack  out  1
- out_valid / out_ready  out / in  1  result handshake
- out_res  out  44  {out1,out2,out3,out4}, signed 11-bit fields
- addr_err  out  1  sticky: an out-of-range vertex read occurred

## Operation
- FSM states: IDLE, FETCH, WAIT, DRIVE, CAPT, OUT. A 2-bit index k is used in FETCH.
- IDLE:
  - If host_wr_req is high: host_wr_ack=1 combinationally, in_ready=0. If host_wr_addr < LUT_DEPTH, then sram_cs=1, sram_we=1, and addr/data are driven that cycle; otherwise the write is acked and dropped.
  - Else in_ready=1. On in_valid, the triplet is latched into calc_* and the FSM goes to FETCH with k=0.
  - Host has strict priority in IDLE; continuous host writes may starve pixels (accepted).
- FETCH (4 cycles):
  - Each cycle issues a read of calc_addr[k] (sram_cs=1, sram_we=0), then k++. After k=3 the FSM goes to WAIT.
  - An out-of-range address is not issued (sram_cs=0). Its word is forced to 0 and addr_err is set.
- Capture: the word from the read issued in cycle c is latched into calc_O[k] at the end of cycle c+1.
- WAIT: captures word 3 and goes to DRIVE.
- DRIVE: calc_O* and calc_* are stable; the calculator registers its results at the end of this cycle. Then go to CAPT.
- CAPT: latch calc_out1..4 into out_res, then go to OUT.
- OUT: out_valid=1. On out_ready, go to IDLE.
- Holds:
  - calc_* is held from accept until the return to IDLE.
  - calc_O* is held until overwritten by the next fetch.
- Host requests arriving outside IDLE wait; host_wr_ack stays 0.
- addr_err clears only on reset.

## Timing
- Reset (rst=0): FSM=IDLE, k=0. The following are all 0: calc_*, calc_O*, out_res, out_valid, in_ready, sram_cs, sram_we, sram_addr, sram_wdata, host_wr_ack, addr_err.
  - Reset asserted mid-operation aborts the pixel with no output. A pending result is discarded.
- Latency:
  - Accept edge E0; reads issued in cycles 1–4; WAIT cycle 5; DRIVE cycle 6; CAPT cycle 7.
  - out_valid rises after E7, i.e. 7 edges after accept.
- Throughput: minimum 9 cycles per pixel (8 busy cycles plus 1 IDLE), with out_ready held high.
- out_res and out_valid are stable under backpressure. The result transfers on the edge where out_valid & out_ready.
- The SRAM is touched only in IDLE (host write) or FETCH (reads); never both in one cycle.
- host_wr_ack is a single-cycle combinational pulse per serviced write. A held host_wr_req gets one write per IDLE cycle.

## Test plan
- Reset then a single pixel (0x50,0x30,0x90) with a behavioural calculator and SRAM model:
  - reads issue to calc_addr0..3 in cycles 1–4;
  - calc_O matches memory in DRIVE;
  - out_valid rises 7 edges after accept;
  - out_res equals the reference tetrahedral sum.
- Host load: write 3392 words (word = addr ^ 0xA5A5A5A5), then addr=3392:
  - 3392 single-cycle acks with sram_we=1;
  - the last request is acked with no sram_cs;
  - read-back via pixels matches.
- Contention: host_wr_req rises together with in_valid in IDLE → host serviced first and in_ready=0 that cycle. Host_wr_req asserted during FETCH → no ack until IDLE.
- Backpressure: out_ready low for 10 cycles →
  - out_res and out_valid are stable;
  - in_ready=0;
  - the next pixel is accepted only after the transfer, then the IDLE cycle.
- Out-of-range: calculator model returns calc_addr2=3856 →
  - no sram_cs in that FETCH cycle;
  - calc_O2=0;
  - addr_err=1 and stays set.
- Reset asserted in WAIT →
  - all outputs 0 immediately;
  - no out_valid;
  - the next pixel completes normally.
